// File: rtl/ctu_jbusr_cken_rst_seq_if.sv
// ctu_jbusr_cken_rst_seq_if: request/status bundle between the jbusr clock-header sequencer and its controller
interface ctu_jbusr_cken_rst_seq_if;
    logic       start_req;
    logic       dbginit_req;
    logic       stop_req;
    logic       se;
    logic       cluster_cken;
    logic       grst_l;
    logic       gdbginit_l;
    logic       ready;
    logic       dbg_done;
    logic [2:0] seq_state;
    modport master (
        output start_req, dbginit_req, stop_req, se,
        input  cluster_cken, grst_l, gdbginit_l, ready, dbg_done, seq_state
    );
    modport slave (
        input  start_req, dbginit_req, stop_req, se,
        output cluster_cken, grst_l, gdbginit_l, ready, dbg_done, seq_state
    );
endinterface

// File: rtl/ctu_jbusr_cken_rst_seq.sv
// ctu_jbusr_cken_rst_seq: orders cluster clock enable, reset release, debug-init pulses and shutdown on gclk
module ctu_jbusr_cken_rst_seq #(
    parameter int CKEN_DLY = 4,
    parameter int RST_DLY  = 8,
    parameter int DBG_CYC  = 16,
    parameter int CNT_W    = 5
) (
    input logic gclk,
    input logic grst,
    ctu_jbusr_cken_rst_seq_if.slave bus
);
    typedef enum logic [2:0] {
        OFF  = 3'd0,
        PRE  = 3'd1,
        RSTW = 3'd2,
        RUN  = 3'd3,
        DBG  = 3'd4,
        STOP = 3'd5
    } state_t;
    if (CKEN_DLY < 1 || RST_DLY < 1 || DBG_CYC < 1 ||
        (1 << CNT_W) <= CKEN_DLY || (1 << CNT_W) <= RST_DLY || (1 << CNT_W) <= DBG_CYC) begin : g_bad_params
        $error("ctu_jbusr_cken_rst_seq: delays must be >=1 and fit in CNT_W bits");
    end
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic cken_q, grst_l_q, gdbginit_l_q, ready_q, dbg_done_q;
    logic last;
    assign last = cnt <= CNT_W'(1);
    // Each timed state exits on the cycle its counter reads 1, so a load of N gives N cycles in the state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            OFF: if (bus.start_req) begin
                state_n = (CKEN_DLY == 1) ? RSTW : PRE;
                cnt_n   = (CKEN_DLY == 1) ? CNT_W'(RST_DLY) : CNT_W'(CKEN_DLY - 1);
            end
            PRE: begin
                state_n = bus.stop_req ? OFF : last ? RSTW : PRE;
                cnt_n   = bus.stop_req ? '0 : last ? CNT_W'(RST_DLY) : cnt - 1'b1;
            end
            RSTW: begin
                state_n = bus.stop_req ? STOP : last ? RUN : RSTW;
                cnt_n   = bus.stop_req ? CNT_W'(RST_DLY) : last ? '0 : cnt - 1'b1;
            end
            RUN: begin
                state_n = bus.stop_req ? STOP : bus.dbginit_req ? DBG : RUN;
                cnt_n   = bus.stop_req ? CNT_W'(RST_DLY) : bus.dbginit_req ? CNT_W'(DBG_CYC) : '0;
            end
            DBG: begin
                state_n = bus.stop_req ? STOP : last ? RUN : DBG;
                cnt_n   = bus.stop_req ? CNT_W'(RST_DLY) : last ? '0 : cnt - 1'b1;
            end
            STOP: begin
                state_n = last ? OFF : STOP;
                cnt_n   = last ? '0 : cnt - 1'b1;
            end
            default: begin
                state_n = OFF;
                cnt_n   = '0;
            end
        endcase
    end
    always_ff @(posedge gclk) begin
        if (grst) begin
            state        <= OFF;
            cnt          <= '0;
            cken_q       <= 1'b0;
            grst_l_q     <= 1'b0;
            gdbginit_l_q <= 1'b0;
            ready_q      <= 1'b0;
            dbg_done_q   <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            cken_q       <= state_n inside {RSTW, RUN, DBG, STOP};
            grst_l_q     <= state_n inside {RUN, DBG};
            gdbginit_l_q <= state_n == RUN;
            ready_q      <= state_n == RUN;
            dbg_done_q   <= state == DBG && state_n == RUN;
        end
    end
    assign bus.cluster_cken = cken_q | bus.se;
    assign bus.grst_l       = grst_l_q;
    assign bus.gdbginit_l   = gdbginit_l_q;
    assign bus.ready        = ready_q;
    assign bus.dbg_done     = dbg_done_q;
    assign bus.seq_state    = state;
endmodule

// File: tb/tb_ctu_jbusr_cken_rst_seq.sv
// tb_ctu_jbusr_cken_rst_seq: directed cycle-numbered checks of the jbusr clock/reset sequencer
module tb_ctu_jbusr_cken_rst_seq;
    logic gclk = 1'b0;
    logic grst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ctu_jbusr_cken_rst_seq_if bus();
    ctu_jbusr_cken_rst_seq dut (.gclk(gclk), .grst(grst), .bus(bus));
    always #5 gclk = ~gclk;
    task automatic tick();
        @(posedge gclk);
        #1;
        cyc++;
    endtask
    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask
    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask
    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask
    task automatic chk_all(input string tag, input logic ck, input logic rl, input logic dl,
                           input logic rdy, input logic dd, input logic [2:0] st);
        chk1({tag, ".cken"}, bus.cluster_cken, ck);
        chk1({tag, ".grst_l"}, bus.grst_l, rl);
        chk1({tag, ".gdbginit_l"}, bus.gdbginit_l, dl);
        chk1({tag, ".ready"}, bus.ready, rdy);
        chk1({tag, ".dbg_done"}, bus.dbg_done, dd);
        chk3({tag, ".state"}, bus.seq_state, st);
    endtask
    initial begin
        grst = 1'b1;
        bus.start_req = 1'b0;
        bus.dbginit_req = 1'b0;
        bus.stop_req = 1'b0;
        bus.se = 1'b0;
        goto(3);
        chk_all("reset", 0, 0, 0, 0, 0, 3'd0);
        grst = 1'b0;
        goto(10);
        chk_all("off_idle", 0, 0, 0, 0, 0, 3'd0);
        // case 1: power-up
        bus.start_req = 1'b1;
        tick();
        bus.start_req = 1'b0;
        chk3("pre_entry", bus.seq_state, 3'd1);
        goto(13);
        chk1("cken_13", bus.cluster_cken, 1'b0);
        goto(14);
        chk_all("rstw_14", 1, 0, 0, 0, 0, 3'd2);
        goto(21);
        chk_all("rstw_21", 1, 0, 0, 0, 0, 3'd2);
        goto(22);
        chk_all("run_22", 1, 1, 1, 1, 0, 3'd3);
        // case 2: debug-init pulse
        goto(30);
        bus.dbginit_req = 1'b1;
        tick();
        bus.dbginit_req = 1'b0;
        chk_all("dbg_31", 1, 1, 0, 0, 0, 3'd4);
        goto(46);
        chk_all("dbg_46", 1, 1, 0, 0, 0, 3'd4);
        goto(47);
        chk_all("dbg_end_47", 1, 1, 1, 1, 1, 3'd3);
        goto(48);
        chk1("dbg_done_48", bus.dbg_done, 1'b0);
        // case 3: stop from RUN
        goto(60);
        bus.stop_req = 1'b1;
        tick();
        bus.stop_req = 1'b0;
        chk_all("stop_61", 1, 0, 0, 0, 0, 3'd5);
        goto(68);
        chk_all("stop_68", 1, 0, 0, 0, 0, 3'd5);
        goto(69);
        chk_all("off_69", 0, 0, 0, 0, 0, 3'd0);
        // case 4: stop and dbginit together in RUN
        goto(75);
        bus.start_req = 1'b1;
        tick();
        bus.start_req = 1'b0;
        goto(87);
        chk_all("run_87", 1, 1, 1, 1, 0, 3'd3);
        goto(90);
        bus.stop_req = 1'b1;
        bus.dbginit_req = 1'b1;
        tick();
        bus.stop_req = 1'b0;
        bus.dbginit_req = 1'b0;
        chk_all("stopdbg_91", 1, 0, 0, 0, 0, 3'd5);
        while (cyc < 99) begin
            tick();
            chk1("no_dbg_done", bus.dbg_done, 1'b0);
        end
        chk_all("off_99", 0, 0, 0, 0, 0, 3'd0);
        // case 5: reset mid-RSTW, ignored requests
        goto(105);
        bus.start_req = 1'b1;
        tick();
        tick();
        bus.start_req = 1'b0;
        goto(108);
        chk3("pre_108", bus.seq_state, 3'd1);
        chk1("pre_cken_108", bus.cluster_cken, 1'b0);
        goto(109);
        chk_all("rstw_109", 1, 0, 0, 0, 0, 3'd2);
        goto(111);
        grst = 1'b1;
        tick();
        grst = 1'b0;
        chk_all("grst_112", 0, 0, 0, 0, 0, 3'd0);
        goto(115);
        bus.start_req = 1'b1;
        tick();
        bus.start_req = 1'b0;
        goto(117);
        bus.dbginit_req = 1'b1;
        tick();
        bus.dbginit_req = 1'b0;
        chk3("pre_dbg_ignored_118", bus.seq_state, 3'd1);
        goto(119);
        chk3("rstw_119", bus.seq_state, 3'd2);
        goto(127);
        chk_all("run_127", 1, 1, 1, 1, 0, 3'd3);
        goto(130);
        bus.start_req = 1'b1;
        tick();
        bus.start_req = 1'b0;
        chk_all("run_start_ignored_131", 1, 1, 1, 1, 0, 3'd3);
        goto(135);
        chk3("run_135", bus.seq_state, 3'd3);
        // stop while still in PRE
        goto(140);
        bus.stop_req = 1'b1;
        tick();
        bus.stop_req = 1'b0;
        goto(149);
        chk_all("off_149", 0, 0, 0, 0, 0, 3'd0);
        goto(150);
        bus.start_req = 1'b1;
        tick();
        bus.start_req = 1'b0;
        goto(152);
        chk3("pre_152", bus.seq_state, 3'd1);
        bus.stop_req = 1'b1;
        tick();
        bus.stop_req = 1'b0;
        chk_all("pre_stop_153", 0, 0, 0, 0, 0, 3'd0);
        goto(156);
        chk_all("off_156", 0, 0, 0, 0, 0, 3'd0);
        // case 6: scan enable
        goto(160);
        bus.se = 1'b1;
        #1;
        chk_all("se_160", 1, 0, 0, 0, 0, 3'd0);
        tick();
        chk_all("se_161", 1, 0, 0, 0, 0, 3'd0);
        bus.se = 1'b0;
        #1;
        chk1("se_off", bus.cluster_cken, 1'b0);
        grst = 1'b1;
        bus.se = 1'b1;
        tick();
        chk_all("se_in_reset", 1, 0, 0, 0, 0, 3'd0);
        grst = 1'b0;
        bus.se = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
